// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain controller.
package fifo_drain_pkg;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned OCC_W      = 2;

  typedef enum logic [1:0] {IDLE, ACTIVE, PAUSE} drain_state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry push/pop buffer with registered head and valid; order preserved.
module skid_buf2
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] tail_data;
  logic [DATA_WIDTH-1:0] head_next;
  logic [DATA_WIDTH-1:0] tail_next;
  logic [OCC_W-1:0]      occ_next;
  logic                  pop_ok;

  assign pop_ok = pop && (occupancy != OCC_W'(0));

  // Next head/tail/occupancy for every push/pop combination
  always_comb begin
    head_next = head_data;
    tail_next = tail_data;
    occ_next  = occupancy;
    case (occupancy)
      OCC_W'(0): begin
        if (push) begin
          head_next = push_data;
          occ_next  = OCC_W'(1);
        end
      end
      OCC_W'(1): begin
        if (push && pop_ok) begin
          head_next = push_data;
        end else if (push) begin
          tail_next = push_data;
          occ_next  = OCC_W'(2);
        end else if (pop_ok) begin
          occ_next  = OCC_W'(0);
        end
      end
      default: begin
        if (pop_ok) begin
          head_next = tail_data;
          if (push) begin
            tail_next = push_data;
          end else begin
            occ_next  = OCC_W'(1);
          end
        end
      end
    endcase
  end

  // Buffer storage and registered valid flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_data  <= '0;
      tail_data  <= '0;
      occupancy  <= '0;
      head_valid <= 1'b0;
    end else begin
      head_data  <= head_next;
      tail_data  <= tail_next;
      occupancy  <= occ_next;
      head_valid <= (occ_next != OCC_W'(0));
    end
  end

endmodule

// File: rtl/fifo_drain_stream.sv
// Read-side controller: issues FIFO reads and presents a valid/ready stream
// through a 2-entry skid buffer that hides the FIFO's 1-cycle read latency.
// Optional statistics (beat_count, stall_seen) when FIFO_DRAIN_STATS_EN is defined.
module fifo_drain_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SKID_DEPTH = fifo_drain_pkg::SKID_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]           beat_count,
  output logic                  stall_seen
`endif
);

  import fifo_drain_pkg::*;

  if (SKID_DEPTH != fifo_drain_pkg::SKID_DEPTH) begin : g_bad_skid_depth
    $error("fifo_drain_stream: SKID_DEPTH must be 2");
  end

  drain_state_e     state;
  drain_state_e     state_next;
  logic             inflight;
  logic [OCC_W-1:0] occupancy;
  logic             pop;
  logic             drained;
  logic [2:0]       committed;

  assign pop       = out_valid && out_ready;
  assign drained   = (occupancy == OCC_W'(0)) && !inflight;
  // Words the buffer will hold after this edge, before counting a new read.
  assign committed = 3'(occupancy) + 3'(inflight) - 3'(pop);

  assign fifo_rd_en = rst_n && enable && !fifo_empty && (state != PAUSE) &&
                      (committed < 3'(SKID_DEPTH));

  // Read-in-flight flag: data returns from the FIFO one cycle after rd_en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (pop),
    .head_valid(out_valid),
    .head_data (out_data),
    .occupancy (occupancy)
  );

  // State register; busy tracks the registered state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (enable && !fifo_empty) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (!enable)                     state_next = PAUSE;
        else if (fifo_empty && drained)  state_next = IDLE;
      end
      PAUSE: begin
        if (enable)       state_next = ACTIVE;
        else if (drained) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FIFO_DRAIN_STATS_EN
  // Delivered-beat counter and sticky consumer-stall flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_count <= 16'd0;
      stall_seen <= 1'b0;
    end else begin
      if (pop) beat_count <= beat_count + 16'd1;
      if (out_valid && !out_ready) stall_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/fifo_drain_stream.md
Name: fifo_drain_stream

Overview:
- Read-side controller that sits directly downstream of the synchronous FIFO.
- Drives the FIFO's rd_en from its empty flag and converts its registered data_out into a valid/ready stream for the next pipeline stage.
- Hides the FIFO's 1-cycle read latency behind a 2-entry skid buffer, sustaining 1 word/cycle while never overrunning the buffer or reading an empty FIFO.

Parameters:
- DATA_WIDTH, 16, width of FIFO data_out and of out_data.
- SKID_DEPTH, 2, skid buffer entries; fixed at 2, any other value triggers an elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  permits new FIFO reads; already-fetched data still drains when low.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  DATA_WIDTH  FIFO read data, valid 1 cycle after an accepted rd_en.
- fifo_rd_en  output  1  read request to the FIFO.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data when valid && ready.
- out_data  output  DATA_WIDTH  head of skid buffer.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (rst_n low at a rising edge): occupancy = 0, inflight = 0, state = IDLE, out_valid = 0, out_data = 0, busy = 0. fifo_rd_en is gated by rst_n, so it is 0 throughout reset.
- pop = out_valid && out_ready.
- fifo_rd_en is combinational: enable && !fifo_empty && state != PAUSE && (occupancy + inflight - pop) < 2.
- inflight is a 1-bit register set to fifo_rd_en each cycle. When inflight = 1, fifo_data_out is written into the buffer at the next edge.
- Buffer is a 2-entry FIFO (head/tail registers). A simultaneous push and pop keeps occupancy constant, and the order is preserved.
- out_valid = (occupancy != 0); out_data = head entry. Both are registered, with no combinational path from out_ready to out_data.
- Latency: the first word appears on out_valid 2 cycles after fifo_empty falls, given enable = 1 and an empty buffer.
- Throughput: with out_ready held at 1, sustains 1 word/cycle.
- Backpressure:
  - out_ready = 0 for N cycles: at most 2 words are buffered and fifo_rd_en drops.
  - No word is lost or duplicated.
- States:
  - IDLE -> ACTIVE when enable && !fifo_empty.
  - ACTIVE -> PAUSE when enable falls.
  - ACTIVE -> IDLE when fifo_empty && occupancy == 0 && inflight == 0.
  - PAUSE issues no reads. PAUSE -> IDLE when occupancy == 0 && inflight == 0. PAUSE -> ACTIVE if enable rises first.
- Boundaries:
  - fifo_empty rising the same cycle as an issued read: the read completes normally, since the FIFO accepted it.
  - The block never asserts fifo_rd_en while fifo_empty = 1, so the FIFO never sees an underflow caused by this block.
  - Reset mid-stream discards buffered and inflight data.

Optional Feature:
- FIFO_DRAIN_STATS_EN defined:
  - Adds output beat_count[15:0], incremented on each pop, wrapping at 16'hFFFF -> 0.
  - Adds output stall_seen (sticky), set when out_valid && !out_ready, cleared only by reset.
  - Both reset to 0.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package fifo_drain_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACTIVE, PAUSE} drain_state_e;
  - localparam SKID_DEPTH = 2.
- One natural sub-module: skid_buf2, the 2-entry push/pop buffer with occupancy output. The controller FSM and read-issue logic stay in the top.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with fifo_empty = 0 and enable = 1 -> fifo_rd_en = 0, out_valid = 0, busy = 0; first rd_en exactly 1 cycle after rst_n rises.
- Streaming: FIFO preloaded with 8 words 0x0001..0x0008, out_ready = 1 -> words appear in order on 8 consecutive cycles, first 2 cycles after the first rd_en, then state returns to IDLE.
- Backpressure: 8 words, out_ready = 0 for cycles 3..10 -> occupancy saturates at 2, rd_en = 0 during the stall, all 8 words delivered once, in order.
- Empty boundary: 1 word 0x00AB, fifo_empty rises the cycle after rd_en -> 0x00AB is delivered and no further rd_en is issued while empty.
- Pause: enable drops with 2 words buffered -> PAUSE, 2 words drain, no new reads, then IDLE; enable high again resumes with the next FIFO word.
- Stats (macro defined): 300 pops -> beat_count = 300; a single-cycle stall sets stall_seen = 1, which holds until reset.
